// File: rtl/fetch_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_ctrl
//  Purpose  : Instruction fetch sequencer. Owns the fetch PC, keeps at most
//             one request outstanding on the req/gnt/rvalid memory port,
//             captures returned words into a single decode slot and applies
//             redirects, discarding responses that were already in flight.
//  Revision : 1.0  initial release
// ============================================================================
module fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  // instruction memory port
  output logic        im_req_o,
  output logic [31:0] im_addr_o,
  input  logic        im_gnt_i,
  input  logic        im_rvalid_i,
  input  logic [31:0] im_rdata_i,
  // decode side
  input  logic        stall_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic [31:0] inst_o,
  output logic [31:0] inst_pc_o,
  output logic        inst_valid_o
);

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    REQ   = 2'd1,
    RESP  = 2'd2,
    DRAIN = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] inst_pc_q, inst_pc_d;
  logic        inst_valid_q, inst_valid_d;

  logic [31:0] w_redirect_pc;
  logic        w_req;
  logic        w_consume;

  // Targets are always word aligned; the low bits are simply masked off.
  assign w_redirect_pc = redirect_pc_i & 32'hFFFF_FFFC;

  // Only ask for a new word if the slot will be free when it comes back:
  // either it is already empty or decode takes it this cycle.
  assign w_req     = (state_q == REQ) && (!inst_valid_q || !stall_i);
  assign w_consume = inst_valid_q && !stall_i;

  // Next-state logic for sequencer, fetch PC and output slot.
  always_comb begin
    state_d      = state_q;
    fetch_pc_d   = fetch_pc_q;
    inst_d       = inst_q;
    inst_pc_d    = inst_pc_q;
    inst_valid_d = inst_valid_q;

    if (w_consume) begin
      inst_valid_d = 1'b0;
    end

    case (state_q)
      BOOT: begin
        state_d = REQ;
      end
      REQ: begin
        // A grant coinciding with a redirect was for the old address.
        if (w_req && im_gnt_i) begin
          state_d = redirect_i ? DRAIN : RESP;
        end
      end
      RESP: begin
        if (im_rvalid_i) begin
          state_d = REQ;
          if (!redirect_i) begin
            inst_d       = im_rdata_i;
            inst_pc_d    = fetch_pc_q;
            inst_valid_d = 1'b1;
            fetch_pc_d   = fetch_pc_q + 32'd4;
          end
        end else if (redirect_i) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        // Stale response: wait for it and throw it away.
        if (im_rvalid_i) begin
          state_d = REQ;
        end
      end
      default: begin
        state_d = BOOT;
      end
    endcase

    // Redirect wins over capture and consume, and kills the slot.
    if (redirect_i) begin
      fetch_pc_d   = w_redirect_pc;
      inst_valid_d = 1'b0;
    end
  end

  // State and slot registers with asynchronous active-low reset.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q      <= BOOT;
      fetch_pc_q   <= RESET_PC;
      inst_q       <= 32'h0;
      inst_pc_q    <= 32'h0;
      inst_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      fetch_pc_q   <= fetch_pc_d;
      inst_q       <= inst_d;
      inst_pc_q    <= inst_pc_d;
      inst_valid_q <= inst_valid_d;
    end
  end

  assign im_req_o     = w_req;
  assign im_addr_o    = fetch_pc_q;
  assign inst_o       = inst_q;
  assign inst_pc_o    = inst_pc_q;
  assign inst_valid_o = inst_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_fetch_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fetch_ctrl
//  Purpose  : Scoreboard bench for fetch_ctrl with a latency-programmable
//             instruction memory model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_fetch_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_n_i = 1'b0;
  logic        im_req_o;
  logic [31:0] im_addr_o;
  logic        im_gnt_i = 1'b0;
  logic        im_rvalid_i = 1'b0;
  logic [31:0] im_rdata_i = 32'h0;
  logic        stall_i = 1'b0;
  logic        redirect_i = 1'b0;
  logic [31:0] redirect_pc_i = 32'h0;
  logic [31:0] inst_o;
  logic [31:0] inst_pc_o;
  logic        inst_valid_o;

  fetch_ctrl #(.RESET_PC(32'h0000_0100)) u_dut (
    .clk_i         (clk_i),
    .rst_n_i       (rst_n_i),
    .im_req_o      (im_req_o),
    .im_addr_o     (im_addr_o),
    .im_gnt_i      (im_gnt_i),
    .im_rvalid_i   (im_rvalid_i),
    .im_rdata_i    (im_rdata_i),
    .stall_i       (stall_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .inst_o        (inst_o),
    .inst_pc_o     (inst_pc_o),
    .inst_valid_o  (inst_valid_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] ins;
  } exp_out_t;

  logic [31:0] exp_req_q[$];
  exp_out_t    exp_out_q[$];

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // memory model state
  int          budget = 0;
  int          lat    = 1;
  bit          pend   = 1'b0;
  int          pcnt   = 0;
  logic [31:0] paddr  = 32'h0;
  bit          ovr_en = 1'b0;
  logic [31:0] ovr_data = 32'h0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h5A5A_A5A5;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  task automatic push_req(input logic [31:0] a);
    exp_req_q.push_back(a);
  endtask

  task automatic push_out(input logic [31:0] pc, input logic [31:0] ins);
    exp_out_t e;
    e.pc  = pc;
    e.ins = ins;
    exp_out_q.push_back(e);
  endtask

  // Memory drive: just after each falling edge, away from the active edge.
  always @(negedge clk_i) begin
    #1;
    if (!rst_n_i) begin
      pend        = 1'b0;
      im_rvalid_i = 1'b0;
    end else if (pend && pcnt <= 1) begin
      im_rvalid_i = 1'b1;
      im_rdata_i  = ovr_en ? ovr_data : mem_word(paddr);
      pend        = 1'b0;
    end else begin
      im_rvalid_i = 1'b0;
      if (pend) pcnt--;
    end
    im_gnt_i = (budget > 0);
  end

  // Monitor: samples 1 ns before the rising edge.
  always @(negedge clk_i) begin
    #4;
    if (rst_n_i) begin
      if (im_req_o && im_gnt_i) begin
        check("req_expected", 32'(exp_req_q.size() != 0), 32'd1);
        if (exp_req_q.size() != 0) check("req_addr", im_addr_o, exp_req_q.pop_front());
        budget--;
        pend  = 1'b1;
        pcnt  = lat;
        paddr = im_addr_o;
      end
      if (inst_valid_o && !stall_i && !redirect_i) begin
        check("out_expected", 32'(exp_out_q.size() != 0), 32'd1);
        if (exp_out_q.size() != 0) begin
          exp_out_t e;
          e = exp_out_q.pop_front();
          check("out_pc", inst_pc_o, e.pc);
          check("out_inst", inst_o, e.ins);
        end
      end
    end
  end

  task automatic go(input int k);
    while (cyc < k) begin
      @(negedge clk_i);
      cyc++;
    end
  endtask

  task automatic smp();
    #4;
  endtask

  task automatic do_reset();
    @(negedge clk_i);
    rst_n_i    = 1'b0;
    stall_i    = 1'b0;
    redirect_i = 1'b0;
    budget     = 0;
    lat        = 1;
    ovr_en     = 1'b0;
    #3;
    check("rst_req", im_req_o, 0);
    check("rst_addr", im_addr_o, 32'h100);
    check("rst_inst", inst_o, 0);
    check("rst_pc", inst_pc_o, 0);
    check("rst_valid", inst_valid_o, 0);
    repeat (2) @(negedge clk_i);
    rst_n_i = 1'b1;
    cyc     = 1;
  endtask

  task automatic wait_drain(input int lim);
    int n = 0;
    while ((exp_req_q.size() != 0 || exp_out_q.size() != 0) && n < lim) begin
      @(negedge clk_i);
      n++;
    end
    check("drain", 32'(exp_req_q.size() + exp_out_q.size()), 0);
    exp_req_q.delete();
    exp_out_q.delete();
    repeat (3) @(negedge clk_i);
  endtask

  bit er[8];
  bit ev[8];

  initial begin
    er = '{0, 0, 1, 0, 1, 0, 1, 0};
    ev = '{0, 0, 0, 0, 1, 0, 1, 0};

    // Boot and zero-wait streaming
    do_reset();
    budget = 3;
    for (int i = 0; i < 3; i++) begin
      push_req(32'h100 + 32'(4 * i));
      push_out(32'h100 + 32'(4 * i), mem_word(32'h100 + 32'(4 * i)));
    end
    for (int k = 1; k < 8; k++) begin
      go(k);
      smp();
      check("s1_req", im_req_o, er[k]);
      check("s1_valid", inst_valid_o, ev[k]);
      if (er[k]) check("s1_addr", im_addr_o, 32'h100 + 32'(4 * (k / 2 - 1)));
    end
    wait_drain(20);

    // Stall holds the slot and blocks requests
    do_reset();
    budget = 2;
    push_req(32'h100); push_out(32'h100, mem_word(32'h100));
    push_req(32'h104); push_out(32'h104, mem_word(32'h104));
    go(6);
    stall_i = 1'b1;
    for (int k = 6; k <= 10; k++) begin
      go(k);
      if (k == 8) begin
        budget = 1;
        push_req(32'h108); push_out(32'h108, mem_word(32'h108));
      end
      smp();
      check("s2_req", im_req_o, 0);
      check("s2_valid", inst_valid_o, 1);
      check("s2_pc", inst_pc_o, 32'h104);
    end
    go(11);
    stall_i = 1'b0;
    smp();
    check("s2_req_rel", im_req_o, 1);
    check("s2_addr_rel", im_addr_o, 32'h108);
    wait_drain(20);

    // Grant wait with redirect (unaligned target)
    do_reset();
    go(2); smp();
    check("s3_req", im_req_o, 1);
    check("s3_addr0", im_addr_o, 32'h100);
    go(3);
    redirect_i = 1'b1; redirect_pc_i = 32'h2002;
    smp();
    check("s3_addr1", im_addr_o, 32'h100);
    go(4);
    redirect_i = 1'b0;
    smp();
    check("s3_addr2", im_addr_o, 32'h2000);
    check("s3_req2", im_req_o, 1);
    go(5);
    budget = 1;
    push_req(32'h2000); push_out(32'h2000, mem_word(32'h2000));
    wait_drain(20);

    // Redirect in RESP, late response dropped
    do_reset();
    lat = 4; budget = 1;
    push_req(32'h100);
    go(3);
    redirect_i = 1'b1; redirect_pc_i = 32'h400;
    ovr_en = 1'b1; ovr_data = 32'h0000_DEAD;
    for (int k = 3; k <= 6; k++) begin
      go(k);
      if (k == 4) redirect_i = 1'b0;
      smp();
      check("s4_valid", inst_valid_o, 0);
      check("s4_req", im_req_o, 0);
      check("s4_rvalid", im_rvalid_i, 32'(k == 6));
    end
    go(7);
    ovr_en = 1'b0;
    smp();
    check("s4_req_tgt", im_req_o, 1);
    check("s4_addr_tgt", im_addr_o, 32'h400);
    check("s4_valid_tgt", inst_valid_o, 0);
    go(8);
    lat = 1; budget = 1;
    push_req(32'h400); push_out(32'h400, mem_word(32'h400));
    wait_drain(20);

    // Redirect together with grant
    do_reset();
    lat = 3; budget = 1;
    push_req(32'h100);
    go(2);
    redirect_i = 1'b1; redirect_pc_i = 32'h800;
    smp();
    check("s5a_req", im_req_o, 1);
    go(3);
    redirect_i = 1'b0;
    smp();
    check("s5a_req_drain", im_req_o, 0);
    check("s5a_addr", im_addr_o, 32'h800);
    go(6);
    lat = 1; budget = 1;
    push_req(32'h800); push_out(32'h800, mem_word(32'h800));
    smp();
    check("s5a_req_tgt", im_req_o, 1);
    check("s5a_valid", inst_valid_o, 0);
    wait_drain(20);

    // Redirect together with rvalid
    do_reset();
    budget = 1;
    push_req(32'h100);
    go(3);
    redirect_i = 1'b1; redirect_pc_i = 32'h900;
    budget = 1;
    push_req(32'h900); push_out(32'h900, mem_word(32'h900));
    smp();
    check("s5b_rvalid", im_rvalid_i, 1);
    go(4);
    redirect_i = 1'b0;
    smp();
    check("s5b_req", im_req_o, 1);
    check("s5b_addr", im_addr_o, 32'h900);
    check("s5b_valid", inst_valid_o, 0);
    wait_drain(20);

    // PC wrap-around
    do_reset();
    go(2);
    redirect_i = 1'b1; redirect_pc_i = 32'hFFFF_FFFC;
    go(3);
    redirect_i = 1'b0;
    smp();
    check("s5c_addr", im_addr_o, 32'hFFFF_FFFC);
    go(4);
    budget = 2;
    push_req(32'hFFFF_FFFC); push_out(32'hFFFF_FFFC, mem_word(32'hFFFF_FFFC));
    push_req(32'h0);         push_out(32'h0, mem_word(32'h0));
    wait_drain(20);

    // Redirect kills a valid, stalled slot
    do_reset();
    stall_i = 1'b1; budget = 1;
    push_req(32'h100);
    go(4); smp();
    check("s5d_valid", inst_valid_o, 1);
    check("s5d_req", im_req_o, 0);
    go(5);
    redirect_i = 1'b1; redirect_pc_i = 32'hA00;
    smp();
    check("s5d_valid_redir", inst_valid_o, 1);
    go(6);
    redirect_i = 1'b0;
    smp();
    check("s5d_killed", inst_valid_o, 0);
    check("s5d_addr", im_addr_o, 32'hA00);
    check("s5d_req2", im_req_o, 1);
    go(7);
    stall_i = 1'b0; budget = 1;
    push_req(32'hA00); push_out(32'hA00, mem_word(32'hA00));
    wait_drain(20);

    // Reset asserted mid-RESP
    do_reset();
    budget = 2;
    push_req(32'h100); push_out(32'h100, mem_word(32'h100));
    push_req(32'h104);
    go(4);
    lat = 6;
    go(5); smp();
    check("s6_hold_pc", inst_pc_o, 32'h100);
    check("s6_hold_inst", inst_o, mem_word(32'h100));
    check("s6_hold_valid", inst_valid_o, 0);
    go(6);
    #2;
    rst_n_i = 1'b0;
    #1;
    check("s6_rst_req", im_req_o, 0);
    check("s6_rst_addr", im_addr_o, 32'h100);
    check("s6_rst_inst", inst_o, 0);
    check("s6_rst_pc", inst_pc_o, 0);
    check("s6_rst_valid", inst_valid_o, 0);
    do_reset();
    budget = 1;
    push_req(32'h100); push_out(32'h100, mem_word(32'h100));
    go(1); smp();
    check("s6_boot_req", im_req_o, 0);
    go(2); smp();
    check("s6_first_req", im_req_o, 1);
    check("s6_first_addr", im_addr_o, 32'h100);
    wait_drain(20);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire

// File: doc/fetch_ctrl.md
# fetch_ctrl

Fetch sequencer for the instruction-memory port. Owns the fetch PC and issues one request at a time to instruction memory over a req/gnt/rvalid handshake, with variable grant and response latency. Captures returned words into a single output slot with the PC they were fetched from, and presents them to decode with a valid/stall handshake. Applies branch and jump redirects, including discarding responses already in flight.

## Interface
- RESET_PC, 32'h0000_0000, first fetch address after reset (low 2 bits must be 0)
- clk_i  in  1  clock, rising edge
- rst_n_i  in  1  reset, asynchronous, active-low
- im_req_o  out  1  request to instruction memory
- im_addr_o  out  32  request address; always equals fetch PC, [1:0] always 0
- im_gnt_i  in  1  memory accepted request (sampled only while im_req_o=1)
- im_rvalid_i  in  1  response data valid; exactly one per grant, at least 1 cycle after grant
- im_rdata_i  in  32  response instruction word
- stall_i  in  1  decode cannot accept the slot this cycle
- redirect_i  in  1  take new PC (branch/jump/trap)
- redirect_pc_i  in  32  redirect target; [1:0] ignored, forced 0
- inst_o  out  32  slot instruction
- inst_pc_o  out  32  PC of inst_o
- inst_valid_o  out  1  slot holds a valid instruction

## Operation
- States: BOOT, REQ, RESP, DRAIN. One outstanding request maximum.
- BOOT: entered on reset. Next edge → REQ. im_req_o=0.
- REQ: im_req_o = !inst_valid_o || !stall_i. This is combinational from stall_i. A request is only issued when the slot will be empty by the time the response returns.
  - req & gnt & !redirect → RESP.
  - req & gnt & redirect → DRAIN; fetch_pc ← redirect_pc. The granted request was for the old address.
  - redirect without gnt → stay REQ; fetch_pc ← redirect_pc. im_addr_o changes the next cycle.
- RESP: im_req_o=0.
  - rvalid & !redirect → inst_o ← rdata, inst_pc_o ← fetch_pc, inst_valid_o ← 1, fetch_pc ← fetch_pc+4 (mod 2^32), → REQ.
  - rvalid & redirect → response dropped; fetch_pc ← redirect_pc; → REQ.
  - redirect without rvalid → fetch_pc ← redirect_pc; → DRAIN.
- DRAIN: im_req_o=0. Waits for the stale response, then discards it.
  - rvalid → REQ.
  - A further redirect updates fetch_pc and stays in DRAIN, unless rvalid arrives in the same cycle, in which case → REQ.
- Slot rules:
  - Consumed at an edge where inst_valid_o=1 & stall_i=0.
  - Cleared (inst_valid_o←0) on consume with no capture, or on any redirect.
  - inst_o and inst_pc_o hold their value while invalid.
  - Invariant: inst_valid_o=0 whenever state=RESP, so capture never overwrites a valid slot.
- Redirect has priority over capture and consume.
- Redirect while the slot is valid kills the slot. inst_valid_o is still 1 during the redirect cycle itself; the redirect source ignores it.
- PC arithmetic: 32-bit unsigned, wraps 0xFFFF_FFFC → 0x0000_0000.

## Timing
- Reset (async assert) sets:
  - im_req_o=0, im_addr_o=RESET_PC
  - inst_o=0, inst_pc_o=0, inst_valid_o=0
  - state=BOOT
- Reset mid-RESP or mid-DRAIN: a response arriving after reset release is ignored, because BOOT/REQ do not sample rvalid. The memory must not return a response for a request issued before reset; this is a system rule.
- First im_req_o=1 occurs in the 2nd cycle after reset release.
- Zero-wait memory (gnt same cycle, rvalid next cycle):
  - gnt at cycle t, rvalid at t+1, inst_valid_o=1 at t+2, next request at t+2.
  - Sustained throughput is 1 instruction per 2 cycles.
- Capture latency: rvalid edge to inst_valid_o is 1 cycle.
- Redirect latency: the target PC appears on im_addr_o in the cycle after redirect_i, and is requested then if state is REQ.

## Test plan
- Reset and boot, RESET_PC=0x100, gnt=1, rvalid one cycle after gnt, stall=0 → addresses 0x100, 0x104, 0x108 requested on cycles 2, 4, 6. inst_pc_o follows with matching rdata; inst_valid_o alternates 1/0.
- Stall: assert stall_i for 5 cycles while the slot holds 0x104 → im_req_o=0, slot unchanged. After release, the next request is 0x108 and no instruction is lost or duplicated.
- Grant wait: hold gnt=0 for 3 cycles with redirect to 0x2000 in the 2nd cycle → im_addr_o switches to 0x2000, and the first captured inst_pc_o is 0x2000.
- Late-response redirect: redirect to 0x400 in RESP, rvalid arrives 3 cycles later with 0xDEAD → the word is dropped, inst_valid_o stays 0, the next request is 0x400.
- Simultaneous events: redirect in the same cycle as gnt goes to DRAIN and the old response is dropped. Redirect in the same cycle as rvalid drops the word and requests the target next cycle. Wrap-around from PC 0xFFFF_FFFC gives next address 0x0.
- Reset asserted mid-RESP → all outputs return to reset values immediately. After release, the first request is RESET_PC.
